// File: rtl/sram_axi_slave.sv
// AXI4 slave endpoint in front of a single-port synchronous SRAM.
// Handles one transaction at a time: a write burst (AW, W beats, B) or a
// read burst (AR, R beats). Every burst is treated as INCR with 4-byte beats.
//
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   AW* / W* / B*         write address, write data and write response channels
//   AR* / R*              read address and read data channels
//   SRAM_CS               chip select, active high
//   SRAM_WEB              per-byte write enable, active low (all ones = read)
//   SRAM_A, SRAM_DI       word address and write data
//   SRAM_DO               read data, valid the cycle after a read access
module sram_axi_slave #(
  parameter int unsigned ID_BITS       = 8,
  parameter int unsigned DATA_BITS     = 32,
  parameter int unsigned MEM_ADDR_BITS = 14,
  localparam int unsigned STRB_BITS    = DATA_BITS / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  // write address channel
  input  logic [ID_BITS-1:0]       AWID,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  // write data channel
  input  logic [DATA_BITS-1:0]     WDATA,
  input  logic [STRB_BITS-1:0]     WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  // write response channel
  output logic [ID_BITS-1:0]       BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  // read address channel
  input  logic [ID_BITS-1:0]       ARID,
  input  logic [31:0]              ARADDR,
  input  logic [3:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  // read data channel
  output logic [ID_BITS-1:0]       RID,
  output logic [DATA_BITS-1:0]     RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  // SRAM port
  output logic                     SRAM_CS,
  output logic [STRB_BITS-1:0]     SRAM_WEB,
  output logic [MEM_ADDR_BITS-1:0] SRAM_A,
  output logic [DATA_BITS-1:0]     SRAM_DI,
  input  logic [DATA_BITS-1:0]     SRAM_DO
);

  typedef enum logic [2:0] {
    StIdle,
    StWData,
    StWResp,
    StRFetch,
    StRWait,
    StRData
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_BITS-1:0]     id_q, id_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             len_q, len_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   rdata_q, rdata_d;
  logic [ID_BITS-1:0]     rid_q, rid_d;
  logic                   rlast_q, rlast_d;

  // Size, burst type and WLAST carry no information for this endpoint.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, WLAST};

  assign BID   = id_q;
  assign BRESP = 2'b00;
  assign RID   = rid_q;
  assign RDATA = rdata_q;
  assign RRESP = 2'b00;
  assign RLAST = rlast_q;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    rlast_d  = rlast_q;

    AWREADY  = 1'b0;
    WREADY   = 1'b0;
    ARREADY  = 1'b0;
    BVALID   = 1'b0;
    RVALID   = 1'b0;
    SRAM_CS  = 1'b0;
    SRAM_WEB = '1;
    SRAM_A   = '0;
    SRAM_DI  = '0;

    unique case (state_q)
      StIdle: begin
        ARREADY = 1'b1;
        AWREADY = !ARVALID;  // reads win a simultaneous request
        if (ARVALID) begin
          id_d    = ARID;
          addr_d  = ARADDR;
          len_d   = ARLEN;
          cnt_d   = '0;
          state_d = StRFetch;
        end else if (AWVALID) begin
          id_d    = AWID;
          addr_d  = AWADDR;
          len_d   = AWLEN;
          cnt_d   = '0;
          state_d = StWData;
        end
      end

      StWData: begin
        WREADY = 1'b1;
        if (WVALID) begin
          SRAM_CS  = 1'b1;
          SRAM_WEB = ~WSTRB;
          SRAM_A   = addr_q[MEM_ADDR_BITS+1:2];
          SRAM_DI  = WDATA;
          addr_d   = addr_q + 32'd4;
          cnt_d    = cnt_q + 4'd1;
          // Beat count, not WLAST, ends the burst.
          if (cnt_q == len_q) begin
            state_d = StWResp;
          end
        end
      end

      StWResp: begin
        BVALID = 1'b1;
        if (BREADY) begin
          state_d = StIdle;
        end
      end

      StRFetch: begin
        SRAM_CS = 1'b1;
        SRAM_A  = addr_q[MEM_ADDR_BITS+1:2];
        state_d = StRWait;
      end

      StRWait: begin
        rdata_d = SRAM_DO;
        rid_d   = id_q;
        rlast_d = (cnt_q == len_q);
        state_d = StRData;
      end

      StRData: begin
        RVALID = 1'b1;
        if (RREADY) begin
          if (rlast_q) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 32'd4;
            cnt_d   = cnt_q + 4'd1;
            state_d = StRFetch;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // While reset is held nothing may be accepted and the SRAM stays idle,
    // even though the state register only clears at the next edge.
    if (ARESET) begin
      AWREADY  = 1'b0;
      WREADY   = 1'b0;
      ARREADY  = 1'b0;
      SRAM_CS  = 1'b0;
      SRAM_WEB = '1;
      SRAM_A   = '0;
      SRAM_DI  = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rid_q   <= '0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      rlast_q <= rlast_d;
    end
  end

endmodule
